mem_stage_lsu: RTL and testbench
================================

// Module: mem_stage_lsu
// PURPOSE
//  MEM-stage load/store unit between the EX_MEM pipeline register and MEM_WB. Issues one data-memory
//  access per load/store over a req/gnt/rvalid bus, aligns and extends load data, and holds the pipe
//  with mem_stall until the access completes. Non-memory instructions pass through with zero latency.
//  Outputs feed MEM_WB directly. MEM_WB has no enable, so a stalled cycle is presented as a bubble.
// PARAMETERS
//  TIMEOUT_CYCLES  256  WAIT-state cycles before a bus error is flagged (used only with MEM_TIMEOUT_EN)
// PORTS
//  clk              in   1   single clock, rising edge
//  rst              in   1   asynchronous, active-high reset
//  ex_alu_result    in   32  effective address for loads/stores, wb candidate otherwise
//  ex_store_data    in   32  rs2 value for stores
//  ex_mem_read      in   1   instruction is a load
//  ex_mem_write     in   1   instruction is a store
//  ex_funct3        in   3   access size/sign: LB,LH,LW,LBU,LHU / SB,SH,SW
//  ex_rd_addr       in   5   destination register
//  ex_reg_write     in   1   instruction writes rd
//  ex_wb_sel        in   2   writeback select, passed through
//  dmem_req         out  1   access request
//  dmem_we          out  1   1 = store
//  dmem_addr        out  32  word-aligned address ({ex_alu_result[31:2],2'b00})
//  dmem_wdata       out  32  store data replicated to all lanes (byte x4, half x2)
//  dmem_wstrb       out  4   byte-lane strobes, 0 for loads
//  dmem_gnt         in   1   request accepted this cycle
//  dmem_rvalid      in   1   load data valid, at least 1 cycle after gnt
//  dmem_rdata       in   32  load word
//  mem_wb_candidate out  32  = ex_alu_result
//  mem_load_data    out  32  aligned, sign/zero-extended load result
//  mem_rd_addr      out  5   = ex_rd_addr
//  mem_reg_write    out  1   ex_reg_write gated: 0 while stalled or misaligned
//  mem_wb_sel       out  2   = ex_wb_sel
//  mem_stall        out  1   hold PC/IF_ID/ID_EX/EX_MEM this cycle
//  mem_misalign     out  1   1-cycle flag: misaligned access, no bus request issued
//  mem_bus_err      out  1   1-cycle flag: load timed out (MEM_TIMEOUT_EN only, else tied 0)
// BEHAVIOUR
//  - FSM states: IDLE, WAIT. Reset (async) -> IDLE, timeout counter 0, captured offset/funct3 0.
//  - During rst, every output reads 0. dmem_req is 0 throughout reset, including reset mid-access.
//  - IDLE, no mem op: pass through with mem_stall=0. mem_load_data=0.
//  - IDLE, aligned mem op: drive dmem_req=1 combinationally.
//    - gnt=0: mem_stall=1, mem_reg_write=0, stay IDLE. Request held until gnt.
//    - store with gnt=1: access complete, mem_stall=0, stay IDLE. One-cycle store when gnt is immediate.
//    - load with gnt=1: capture addr[1:0] and funct3, go to WAIT. mem_stall=1 in this cycle.
//  - WAIT: dmem_req=0, mem_stall=1, mem_reg_write=0 until dmem_rvalid.
//    - On rvalid: mem_stall=0, mem_load_data from rdata and the captured offset/funct3,
//      mem_reg_write=ex_reg_write, go to IDLE.
//  - Alignment: LH/LHU/SH need addr[0]=0. LW/SW need addr[1:0]=0.
//    - Violation: dmem_req=0, mem_misalign=1 for one cycle, mem_reg_write=0, mem_stall=0.
//  - Extension: LB/LH sign-extend bit 7/15. LBU/LHU zero-extend. LW passes the word.
//  - Strobes: SB 4'b0001<<a[1:0], SH 4'b0011<<a[1:0] (a[1] set gives 1100), SW 4'b1111.
//  - One outstanding access at most. EX_MEM inputs are stable while mem_stall=1.
//  - Simultaneous mem_read and mem_write: treated as load.
//  - funct3 values outside the table: treated as word access.
// CONFIGURATION
//  MEM_TIMEOUT_EN defined: 9-bit counter runs in WAIT and clears on entry to WAIT.
//    - Counter reaches TIMEOUT_CYCLES-1 without rvalid: mem_bus_err=1 for 1 cycle,
//      mem_reg_write=0, mem_stall=0, return to IDLE.
//    - A late rvalid arriving in IDLE is ignored.
//  MEM_TIMEOUT_EN undefined: no counter, WAIT is unbounded, mem_bus_err tied 0.
// STRUCTURE
//  rv_mem_pkg (shared): funct3 localparams for LB..LHU and SB..SW, FSM state encodings, WB_SEL codes.
//  Sub-module mem_load_align (combinational): rdata, offset, funct3 -> extended load data.
//    Reused by any future cache path.
// TESTING
//  1 LW addr 0x100, gnt same cycle, rvalid 2 cycles later with rdata 0xDEADBEEF
//    -> stall high 2 cycles, then mem_load_data=0xDEADBEEF and reg_write=1.
//  2 LB addr 0x103 with rdata 0x80112233 -> 0xFFFFFF80. LBU, same stimulus -> 0x00000080.
//    LHU addr 0x102 -> 0x00008011.
//  3 SH addr 0x202 with data 0x0000ABCD -> wstrb=1100, wdata=0xABCDABCD, addr=0x200.
//    gnt delayed 3 cycles -> stall high exactly 3 cycles.
//  4 LW addr 0x101 -> no dmem_req, mem_misalign pulses once, reg_write=0, stall=0.
//  5 Assert rst while in WAIT -> all outputs 0, dmem_req 0.
//    After release, an ADD passes through with no stall.
//  6 MEM_TIMEOUT_EN with TIMEOUT_CYCLES=8 and no rvalid -> mem_bus_err pulses once,
//    stall drops, FSM returns to IDLE.

Source files
------------

// File: rtl/rv_mem_pkg.sv
// Shared RV32 memory-stage definitions: funct3 codes, LSU FSM states, writeback select codes
// and the access-size decode used by the load/store unit and the load aligner.
package rv_mem_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    localparam logic [1:0] WB_SEL_ALU = 2'd0;
    localparam logic [1:0] WB_SEL_MEM = 2'd1;
    localparam logic [1:0] WB_SEL_PC4 = 2'd2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } lsu_state_e;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } acc_size_e;

    // Any funct3 outside the load or store table falls back to a word access.
    function automatic acc_size_e access_size(input logic [2:0] f3, input logic is_store);
        acc_size_e sz;
        sz = SZ_WORD;
        if (is_store) begin
            case (f3)
                F3_SB:   sz = SZ_BYTE;
                F3_SH:   sz = SZ_HALF;
                F3_SW:   sz = SZ_WORD;
                default: sz = SZ_WORD;
            endcase
        end else begin
            case (f3)
                F3_LB, F3_LBU: sz = SZ_BYTE;
                F3_LH, F3_LHU: sz = SZ_HALF;
                F3_LW:         sz = SZ_WORD;
                default:       sz = SZ_WORD;
            endcase
        end
        return sz;
    endfunction

endpackage

// File: rtl/mem_load_align.sv
// Combinational load aligner: selects the addressed byte/half of a bus word and
// sign- or zero-extends it according to funct3.
module mem_load_align
    import rv_mem_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    output logic [31:0] load_data
);

    logic [31:0] shifted;

    always_comb begin
        shifted = rdata >> {offset, 3'b000};
        case (funct3)
            F3_LB:   load_data = {{24{shifted[7]}}, shifted[7:0]};
            F3_LH:   load_data = {{16{shifted[15]}}, shifted[15:0]};
            F3_LBU:  load_data = {24'd0, shifted[7:0]};
            F3_LHU:  load_data = {16'd0, shifted[15:0]};
            default: load_data = shifted;
        endcase
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: one req/gnt/rvalid data access per load/store, stalls the pipe
// until it completes. Optional load timeout enabled by defining MEM_TIMEOUT_EN.
module mem_stage_lsu
    import rv_mem_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] ex_alu_result,
    input  logic [31:0] ex_store_data,
    input  logic        ex_mem_read,
    input  logic        ex_mem_write,
    input  logic [2:0]  ex_funct3,
    input  logic [4:0]  ex_rd_addr,
    input  logic        ex_reg_write,
    input  logic [1:0]  ex_wb_sel,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_wstrb,
    input  logic        dmem_gnt,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata,
    output logic [31:0] mem_wb_candidate,
    output logic [31:0] mem_load_data,
    output logic [4:0]  mem_rd_addr,
    output logic        mem_reg_write,
    output logic [1:0]  mem_wb_sel,
    output logic        mem_stall,
    output logic        mem_misalign,
    output logic        mem_bus_err
);

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 512) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be in 2..512 to fit the 9-bit wait counter");
    end

    lsu_state_e  state_q, state_d;
    logic [1:0]  off_q, off_d;
    logic [2:0]  f3_q, f3_d;

    logic        is_load, is_store, is_mem, misalign;
    acc_size_e   size;
    logic [31:0] align_data;
    logic        timeout;

    logic        req, stall, misal_flag, berr_flag, rw;
    logic [31:0] ld_data;
    logic [31:0] wdata;
    logic [3:0]  wstrb;

    // A read+write combination is treated as a load.
    assign is_load  = ex_mem_read;
    assign is_store = ex_mem_write & ~ex_mem_read;
    assign is_mem   = is_load | is_store;
    assign size     = access_size(ex_funct3, is_store);

    always_comb begin
        case (size)
            SZ_HALF: misalign = ex_alu_result[0];
            SZ_WORD: misalign = |ex_alu_result[1:0];
            default: misalign = 1'b0;
        endcase
    end

    always_comb begin
        case (size)
            SZ_BYTE: begin
                wdata = {4{ex_store_data[7:0]}};
                wstrb = 4'b0001 << ex_alu_result[1:0];
            end
            SZ_HALF: begin
                wdata = {2{ex_store_data[15:0]}};
                wstrb = 4'b0011 << ex_alu_result[1:0];
            end
            default: begin
                wdata = ex_store_data;
                wstrb = 4'b1111;
            end
        endcase
    end

    mem_load_align u_align (
        .rdata     (dmem_rdata),
        .offset    (off_q),
        .funct3    (f3_q),
        .load_data (align_data)
    );

`ifdef MEM_TIMEOUT_EN
    localparam logic [8:0] TIMEOUT_LAST = 9'(TIMEOUT_CYCLES - 1);

    logic [8:0] cnt_q, cnt_d;

    // Held at zero in IDLE so every WAIT episode starts counting from 0.
    always_comb begin
        cnt_d = cnt_q;
        if (state_q == ST_IDLE) begin
            cnt_d = 9'd0;
        end else if (!dmem_rvalid) begin
            cnt_d = cnt_q + 9'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= 9'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign timeout = (state_q == ST_WAIT) && !dmem_rvalid && (cnt_q == TIMEOUT_LAST);
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        off_d      = off_q;
        f3_d       = f3_q;
        req        = 1'b0;
        stall      = 1'b0;
        misal_flag = 1'b0;
        berr_flag  = 1'b0;
        rw         = ex_reg_write;
        ld_data    = 32'd0;
        case (state_q)
            ST_IDLE: begin
                if (is_mem) begin
                    if (misalign) begin
                        misal_flag = 1'b1;
                        rw         = 1'b0;
                    end else begin
                        req = 1'b1;
                        if (!dmem_gnt) begin
                            stall = 1'b1;
                            rw    = 1'b0;
                        end else if (is_load) begin
                            stall   = 1'b1;
                            rw      = 1'b0;
                            state_d = ST_WAIT;
                            off_d   = ex_alu_result[1:0];
                            f3_d    = ex_funct3;
                        end
                    end
                end
            end
            ST_WAIT: begin
                rw = 1'b0;
                if (dmem_rvalid) begin
                    ld_data = align_data;
                    rw      = ex_reg_write;
                    state_d = ST_IDLE;
                end else if (timeout) begin
                    berr_flag = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    stall = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            off_q   <= 2'd0;
            f3_q    <= 3'd0;
        end else begin
            state_q <= state_d;
            off_q   <= off_d;
            f3_q    <= f3_d;
        end
    end

    // Outputs are forced low for the whole reset interval, including a reset mid-access.
    always_comb begin
        dmem_req         = 1'b0;
        dmem_we          = 1'b0;
        dmem_addr        = 32'd0;
        dmem_wdata       = 32'd0;
        dmem_wstrb       = 4'd0;
        mem_wb_candidate = 32'd0;
        mem_load_data    = 32'd0;
        mem_rd_addr      = 5'd0;
        mem_reg_write    = 1'b0;
        mem_wb_sel       = 2'd0;
        mem_stall        = 1'b0;
        mem_misalign     = 1'b0;
        mem_bus_err      = 1'b0;
        if (!rst) begin
            dmem_req         = req;
            dmem_we          = req & is_store;
            dmem_addr        = {ex_alu_result[31:2], 2'b00};
            dmem_wdata       = wdata;
            dmem_wstrb       = (req & is_store) ? wstrb : 4'd0;
            mem_wb_candidate = ex_alu_result;
            mem_load_data    = ld_data;
            mem_rd_addr      = ex_rd_addr;
            mem_reg_write    = rw;
            mem_wb_sel       = ex_wb_sel;
            mem_stall        = stall;
            mem_misalign     = misal_flag;
            mem_bus_err      = berr_flag;
        end
    end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu: loads, stores, misalignment, reset mid-access and,
// when MEM_TIMEOUT_EN is defined, the load timeout path.
module tb_mem_stage_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] ex_alu_result, ex_store_data;
    logic        ex_mem_read, ex_mem_write;
    logic [2:0]  ex_funct3;
    logic [4:0]  ex_rd_addr;
    logic        ex_reg_write;
    logic [1:0]  ex_wb_sel;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_wstrb;
    logic        dmem_gnt, dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic [31:0] mem_wb_candidate, mem_load_data;
    logic [4:0]  mem_rd_addr;
    logic        mem_reg_write;
    logic [1:0]  mem_wb_sel;
    logic        mem_stall, mem_misalign, mem_bus_err;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_stage_lsu #(.TIMEOUT_CYCLES(8)) dut (
        .clk              (clk),
        .rst              (rst),
        .ex_alu_result    (ex_alu_result),
        .ex_store_data    (ex_store_data),
        .ex_mem_read      (ex_mem_read),
        .ex_mem_write     (ex_mem_write),
        .ex_funct3        (ex_funct3),
        .ex_rd_addr       (ex_rd_addr),
        .ex_reg_write     (ex_reg_write),
        .ex_wb_sel        (ex_wb_sel),
        .dmem_req         (dmem_req),
        .dmem_we          (dmem_we),
        .dmem_addr        (dmem_addr),
        .dmem_wdata       (dmem_wdata),
        .dmem_wstrb       (dmem_wstrb),
        .dmem_gnt         (dmem_gnt),
        .dmem_rvalid      (dmem_rvalid),
        .dmem_rdata       (dmem_rdata),
        .mem_wb_candidate (mem_wb_candidate),
        .mem_load_data    (mem_load_data),
        .mem_rd_addr      (mem_rd_addr),
        .mem_reg_write    (mem_reg_write),
        .mem_wb_sel       (mem_wb_sel),
        .mem_stall        (mem_stall),
        .mem_misalign     (mem_misalign),
        .mem_bus_err      (mem_bus_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_op(input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] sdata,
                          input logic [4:0] rda, input logic regw, input logic [1:0] wbs);
        ex_mem_read   = rd;
        ex_mem_write  = wr;
        ex_funct3     = f3;
        ex_alu_result = addr;
        ex_store_data = sdata;
        ex_rd_addr    = rda;
        ex_reg_write  = regw;
        ex_wb_sel     = wbs;
    endtask

    task automatic nop();
        set_op(1'b0, 1'b0, 3'b000, 32'd0, 32'd0, 5'd0, 1'b0, 2'd0);
        dmem_gnt    = 1'b0;
        dmem_rvalid = 1'b0;
        dmem_rdata  = 32'd0;
    endtask

    // Inputs change just after the rising edge; outputs are sampled on the falling edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] rdata, input logic [31:0] exp);
        step();
        set_op(1'b1, 1'b0, f3, addr, 32'd0, 5'd7, 1'b1, 2'd1);
        dmem_gnt = 1'b1;
        sample();
        chk({tag, "_stall_gnt"}, 32'(mem_stall), 32'd1);
        step();
        dmem_gnt    = 1'b0;
        dmem_rvalid = 1'b1;
        dmem_rdata  = rdata;
        sample();
        chk({tag, "_data"}, mem_load_data, exp);
        chk({tag, "_stall_done"}, 32'(mem_stall), 32'd0);
        step();
        nop();
    endtask

    initial begin
        int stalls;
        rst = 1'b1;
        nop();
        set_op(1'b1, 1'b0, 3'b010, 32'h100, 32'h55, 5'd9, 1'b1, 2'd1);
        dmem_gnt = 1'b1;

        // reset: every output low
        sample();
        chk("rst_req", 32'(dmem_req), 32'd0);
        chk("rst_stall", 32'(mem_stall), 32'd0);
        chk("rst_wbcand", mem_wb_candidate, 32'd0);
        chk("rst_rd", 32'(mem_rd_addr), 32'd0);
        chk("rst_regw", 32'(mem_reg_write), 32'd0);

        // 1: LW 0x100, gnt immediately, rvalid two cycles after gnt
        step();
        rst = 1'b0;
        set_op(1'b1, 1'b0, 3'b010, 32'h100, 32'd0, 5'd5, 1'b1, 2'd1);
        dmem_gnt = 1'b1;
        sample();
        chk("lw_req", 32'(dmem_req), 32'd1);
        chk("lw_we", 32'(dmem_we), 32'd0);
        chk("lw_addr", dmem_addr, 32'h100);
        chk("lw_wstrb", 32'(dmem_wstrb), 32'd0);
        chk("lw_stall0", 32'(mem_stall), 32'd1);
        chk("lw_regw0", 32'(mem_reg_write), 32'd0);
        step();
        dmem_gnt = 1'b0;
        sample();
        chk("lw_req_wait", 32'(dmem_req), 32'd0);
        chk("lw_stall1", 32'(mem_stall), 32'd1);
        chk("lw_buserr_wait", 32'(mem_bus_err), 32'd0);
        step();
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'hDEADBEEF;
        sample();
        chk("lw_stall2", 32'(mem_stall), 32'd0);
        chk("lw_data", mem_load_data, 32'hDEADBEEF);
        chk("lw_regw", 32'(mem_reg_write), 32'd1);
        chk("lw_rd", 32'(mem_rd_addr), 32'd5);
        step();
        nop();
        sample();
        chk("nop_loaddata", mem_load_data, 32'd0);

        // 2: byte/half extraction and extension
        do_load("lb", 3'b000, 32'h103, 32'h80112233, 32'hFFFFFF80);
        do_load("lbu", 3'b100, 32'h103, 32'h80112233, 32'h00000080);
        do_load("lhu", 3'b101, 32'h102, 32'h80112233, 32'h00008011);
        do_load("lh", 3'b001, 32'h102, 32'h80112233, 32'hFFFF8011);

        // 3: SH 0x202 with gnt held off for 3 cycles
        step();
        set_op(1'b0, 1'b1, 3'b001, 32'h202, 32'h0000ABCD, 5'd0, 1'b0, 2'd0);
        dmem_gnt = 1'b0;
        sample();
        chk("sh_wstrb", 32'(dmem_wstrb), 32'hC);
        chk("sh_wdata", dmem_wdata, 32'hABCDABCD);
        chk("sh_addr", dmem_addr, 32'h200);
        chk("sh_we", 32'(dmem_we), 32'd1);
        stalls = 32'(mem_stall);
        for (int i = 0; i < 2; i++) begin
            step();
            sample();
            stalls += 32'(mem_stall);
            chk("sh_req_held", 32'(dmem_req), 32'd1);
        end
        step();
        dmem_gnt = 1'b1;
        sample();
        stalls += 32'(mem_stall);
        chk("sh_stall_cycles", 32'(stalls), 32'd3);
        chk("sh_gnt_stall", 32'(mem_stall), 32'd0);
        step();
        nop();

        // SB at offset 1: strobe and lane replication
        set_op(1'b0, 1'b1, 3'b000, 32'h301, 32'h000000A5, 5'd0, 1'b0, 2'd0);
        dmem_gnt = 1'b1;
        sample();
        chk("sb_wstrb", 32'(dmem_wstrb), 32'h2);
        chk("sb_wdata", dmem_wdata, 32'hA5A5A5A5);
        chk("sb_stall", 32'(mem_stall), 32'd0);
        step();
        nop();

        // 4: misaligned LW 0x101
        set_op(1'b1, 1'b0, 3'b010, 32'h101, 32'd0, 5'd4, 1'b1, 2'd1);
        dmem_gnt = 1'b1;
        sample();
        chk("mis_req", 32'(dmem_req), 32'd0);
        chk("mis_flag", 32'(mem_misalign), 32'd1);
        chk("mis_regw", 32'(mem_reg_write), 32'd0);
        chk("mis_stall", 32'(mem_stall), 32'd0);
        step();
        nop();
        sample();
        chk("mis_flag_clear", 32'(mem_misalign), 32'd0);

        // 5: reset asserted while waiting for rvalid
        step();
        set_op(1'b1, 1'b0, 3'b010, 32'h100, 32'd0, 5'd6, 1'b1, 2'd1);
        dmem_gnt = 1'b1;
        step();
        dmem_gnt = 1'b0;
        rst = 1'b1;
        sample();
        chk("rstw_req", 32'(dmem_req), 32'd0);
        chk("rstw_stall", 32'(mem_stall), 32'd0);
        chk("rstw_wbcand", mem_wb_candidate, 32'd0);
        chk("rstw_regw", 32'(mem_reg_write), 32'd0);
        step();
        rst = 1'b0;
        set_op(1'b0, 1'b0, 3'b000, 32'h00001234, 32'd0, 5'd3, 1'b1, 2'd0);
        sample();
        chk("add_stall", 32'(mem_stall), 32'd0);
        chk("add_regw", 32'(mem_reg_write), 32'd1);
        chk("add_wbcand", mem_wb_candidate, 32'h00001234);
        chk("add_req", 32'(dmem_req), 32'd0);
        step();
        nop();

`ifdef MEM_TIMEOUT_EN
        // 6: load with no rvalid times out after 8 WAIT cycles
        set_op(1'b1, 1'b0, 3'b010, 32'h100, 32'd0, 5'd8, 1'b1, 2'd1);
        dmem_gnt = 1'b1;
        step();
        dmem_gnt = 1'b0;
        for (int i = 0; i < 7; i++) begin
            sample();
            chk("to_wait_stall", 32'(mem_stall), 32'd1);
            chk("to_wait_err", 32'(mem_bus_err), 32'd0);
            step();
        end
        sample();
        chk("to_err", 32'(mem_bus_err), 32'd1);
        chk("to_stall", 32'(mem_stall), 32'd0);
        chk("to_regw", 32'(mem_reg_write), 32'd0);
        step();
        nop();
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'hCAFEF00D;
        sample();
        chk("to_idle_stall", 32'(mem_stall), 32'd0);
        chk("to_err_clear", 32'(mem_bus_err), 32'd0);
        chk("to_late_rvalid", mem_load_data, 32'd0);
        step();
        nop();
`else
        // without the timeout the wait is unbounded and bus_err stays low
        set_op(1'b1, 1'b0, 3'b010, 32'h100, 32'd0, 5'd8, 1'b1, 2'd1);
        dmem_gnt = 1'b1;
        step();
        dmem_gnt = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
        end
        sample();
        chk("nto_stall", 32'(mem_stall), 32'd1);
        chk("nto_err", 32'(mem_bus_err), 32'd0);
        step();
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'h12345678;
        sample();
        chk("nto_data", mem_load_data, 32'h12345678);
        step();
        nop();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
